// File: rtl/mem_access_pkg.sv
// Shared op codes, FSM state encoding and alignment helpers for the load/store front end.
package mem_access_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_e;

    // Word ops need both low bits clear, halfword ops need bit 0 clear; bytes are always aligned.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
        logic r;
        r = 1'b0;
        case (op)
            OP_LW, OP_SW:          r = (off != 2'b00);
            OP_LH, OP_LHU, OP_SH:  r = off[0];
            default:               r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_store(input logic [2:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Combinational load formatter: picks the addressed lane of a DM word and sign/zero-extends it.
module lsu_load_fmt
    import mem_access_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_off,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Little-endian lane selection followed by extension according to the load flavour.
    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        o_data = 32'h0000_0000;
        case (i_off)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = 8'h00;
        endcase
        if (i_off[1]) begin
            w_half = i_word[31:16];
        end else begin
            w_half = i_word[15:0];
        end
        case (i_op)
            OP_LW:   o_data = i_word;
            OP_LH:   o_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_data = {16'h0000, w_half};
            OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_data = {24'h000000, w_byte};
            default: o_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for the word-only data memory: one request in flight,
// read-modify-write for sub-word stores, misaligned accesses answered without touching DM.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int AW              = 12,
    parameter bit ERR_ON_MISALIGN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic          dm_wr,
    output logic [AW-3:0] dm_addr,
    output logic [31:0]   dm_din,
    input  logic [31:0]   dm_dout
);

    state_e        r_state;
    state_e        w_state_nxt;
    logic [2:0]    r_op;
    logic [1:0]    r_off;
    logic [15:0]   r_wdata;
    logic          r_err;
    logic [31:0]   r_rdata;
    logic [AW-3:0] r_dm_addr;
    logic [31:0]   r_dm_din;

    logic [AW-1:0] w_acc_addr;
    logic          w_mis;
    logic [31:0]   w_load_data;
    logic [31:0]   w_merged;

    assign w_mis = ERR_ON_MISALIGN && is_misaligned(req_op, req_addr[1:0]);

    // When misalignment is tolerated the offending low address bits are simply dropped.
    always_comb begin
        w_acc_addr = req_addr;
        if (!ERR_ON_MISALIGN) begin
            case (req_op)
                OP_LW, OP_SW:         w_acc_addr[1:0] = 2'b00;
                OP_LH, OP_LHU, OP_SH: w_acc_addr[0]   = 1'b0;
                default:              w_acc_addr      = req_addr;
            endcase
        end else begin
            w_acc_addr = req_addr;
        end
    end

    lsu_load_fmt u_load_fmt (
        .i_word (dm_dout),
        .i_op   (r_op),
        .i_off  (r_off),
        .o_data (w_load_data)
    );

    // Store merge: replace only the addressed lane of the word just read back from DM.
    always_comb begin
        w_merged = dm_dout;
        if (r_op == OP_SB) begin
            case (r_off)
                2'd0:    w_merged[7:0]   = r_wdata[7:0];
                2'd1:    w_merged[15:8]  = r_wdata[7:0];
                2'd2:    w_merged[23:16] = r_wdata[7:0];
                2'd3:    w_merged[31:24] = r_wdata[7:0];
                default: w_merged        = dm_dout;
            endcase
        end else if (r_op == OP_SH) begin
            if (r_off[1]) begin
                w_merged[31:16] = r_wdata;
            end else begin
                w_merged[15:0] = r_wdata;
            end
        end else begin
            w_merged = dm_dout;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_mis) begin
                        w_state_nxt = ST_RESP;
                    end else if (req_op == OP_SW) begin
                        w_state_nxt = ST_WR;
                    end else begin
                        w_state_nxt = ST_RD;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RD:   w_state_nxt = ST_CAP;
            ST_CAP: begin
                if (is_store(r_op)) begin
                    w_state_nxt = ST_WR;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_WR:   w_state_nxt = ST_RESP;
            ST_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request capture, load result capture and DM address/data staging.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= 3'd0;
            r_off     <= 2'd0;
            r_wdata   <= 16'h0000;
            r_err     <= 1'b0;
            r_rdata   <= 32'h0000_0000;
            r_dm_addr <= '0;
            r_dm_din  <= 32'h0000_0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_op    <= req_op;
                        r_off   <= w_acc_addr[1:0];
                        r_wdata <= req_wdata[15:0];
                        r_err   <= w_mis;
                        r_rdata <= 32'h0000_0000;
                        // DM-facing registers only move for accesses that will reach DM.
                        if (!w_mis) begin
                            r_dm_addr <= w_acc_addr[AW-1:2];
                            if (req_op == OP_SW) begin
                                r_dm_din <= req_wdata;
                            end
                        end
                    end
                end
                ST_CAP: begin
                    if (is_store(r_op)) begin
                        r_dm_din <= w_merged;
                    end else begin
                        r_rdata <= w_load_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign dm_wr      = (r_state == ST_WR) && !rst;
    assign dm_addr    = r_dm_addr;
    assign dm_din     = r_dm_din;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word-wide data memory.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [11:0] req_addr = 12'h000;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        dm_wr;
    logic [9:0]  dm_addr;
    logic [31:0] dm_din;
    logic [31:0] dm_dout = 32'h0;

    logic [31:0] mem [0:1023] = '{default: 32'h0};

    int n_checks = 0;
    int n_fail   = 0;
    int lat;
    int pulses;
    logic [9:0]  wr_addr;
    logic [31:0] wr_din;
    logic [31:0] held;

    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                           LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

    always #5 clk = ~clk;

    // Word memory: synchronous write, registered read valid the cycle after the edge.
    always @(posedge clk) begin
        if (dm_wr) mem[dm_addr] <= dm_din;
        dm_dout <= mem[dm_addr];
    end

    mem_access_unit #(.AW(12), .ERR_ON_MISALIGN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dm_wr      (dm_wr),
        .dm_addr    (dm_addr),
        .dm_din     (dm_din),
        .dm_dout    (dm_dout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [11:0] a, input logic [31:0] wd);
        req_op    = op;
        req_addr  = a;
        req_wdata = wd;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    // Counts cycles after the accept edge until resp_valid, recording any DM write.
    task automatic wait_resp();
        lat    = 1;
        pulses = 0;
        while (!resp_valid && lat < 20) begin
            if (dm_wr) begin
                pulses++;
                wr_addr = dm_addr;
                wr_din  = dm_din;
            end
            tick();
            lat++;
        end
    endtask

    task automatic retire();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [11:0] a,
                       input logic [31:0] wd, input int exp_lat, input int exp_pulses,
                       input logic [31:0] exp_rdata, input logic exp_err);
        issue(op, a, wd);
        wait_resp();
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " wr pulses"}, pulses, exp_pulses);
        check({tag, " rdata"}, resp_rdata, exp_rdata);
        check({tag, " err"}, {31'b0, resp_err}, {31'b0, exp_err});
        retire();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        tick();
        check("rst req_ready", {31'b0, req_ready}, 32'd1);
        check("rst resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst dm_wr", {31'b0, dm_wr}, 32'd0);
        check("rst resp_rdata", resp_rdata, 32'h0);
        check("rst resp_err", {31'b0, resp_err}, 32'd0);
        check("rst dm_addr", {22'b0, dm_addr}, 32'd0);
        check("rst dm_din", dm_din, 32'h0);
        rst = 1'b0;
        tick();

        // Full-word store then load
        run("SW 010", SW, 12'h010, 32'hDEADBEEF, 2, 1, 32'h0, 1'b0);
        check("SW 010 dm_addr", {22'b0, wr_addr}, 32'd4);
        check("SW 010 dm_din", wr_din, 32'hDEADBEEF);
        check("SW 010 mem", mem[4], 32'hDEADBEEF);
        run("LW 010", LW, 12'h010, 32'h0, 3, 0, 32'hDEADBEEF, 1'b0);

        // Byte store via read-modify-write, then byte loads
        run("SB 013", SB, 12'h013, 32'h000000A5, 4, 1, 32'h0, 1'b0);
        check("SB 013 mem", mem[4], 32'hA5ADBEEF);
        run("LB 013", LB, 12'h013, 32'h0, 3, 0, 32'hFFFFFFA5, 1'b0);
        run("LBU 013", LBU, 12'h013, 32'h0, 3, 0, 32'h000000A5, 1'b0);
        run("LB 011", LB, 12'h011, 32'h0, 3, 0, 32'hFFFFFFBE, 1'b0);
        run("LBU 010", LBU, 12'h010, 32'h0, 3, 0, 32'h000000EF, 1'b0);

        // Halfword store and loads
        run("SH 012", SH, 12'h012, 32'h00001234, 4, 1, 32'h0, 1'b0);
        check("SH 012 mem", mem[4], 32'h1234BEEF);
        run("LH 012", LH, 12'h012, 32'h0, 3, 0, 32'h00001234, 1'b0);
        run("LH 010", LH, 12'h010, 32'h0, 3, 0, 32'hFFFFBEEF, 1'b0);
        run("LHU 010", LHU, 12'h010, 32'h0, 3, 0, 32'h0000BEEF, 1'b0);

        // Misaligned accesses
        run("LW 011", LW, 12'h011, 32'h0, 1, 0, 32'h0, 1'b1);
        run("SH 013", SH, 12'h013, 32'h0000FFFF, 1, 0, 32'h0, 1'b1);
        check("misaligned mem", mem[4], 32'h1234BEEF);
        check("misaligned dm_addr hold", {22'b0, dm_addr}, 32'd4);

        // Response backpressure with competing request
        issue(LW, 12'h010, 32'h0);
        wait_resp();
        check("bp latency", lat, 3);
        held = 32'h1234BEEF;
        req_op    = SW;
        req_addr  = 12'h020;
        req_wdata = 32'h55AA55AA;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp resp_valid", {31'b0, resp_valid}, 32'd1);
            check("bp rdata held", resp_rdata, held);
            check("bp req_ready", {31'b0, req_ready}, 32'd0);
            check("bp dm_wr", {31'b0, dm_wr}, 32'd0);
        end
        req_valid = 1'b0;
        retire();
        check("bp retired resp_valid", {31'b0, resp_valid}, 32'd0);
        check("bp retired req_ready", {31'b0, req_ready}, 32'd1);
        check("bp mem untouched", mem[8], 32'h0);

        // Reset asserted during the write cycle of a byte store
        issue(SB, 12'h010, 32'h00000077);
        tick();
        tick();
        check("rst-in-WR dm_wr before", {31'b0, dm_wr}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst-in-WR dm_wr", {31'b0, dm_wr}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rst-in-WR req_ready", {31'b0, req_ready}, 32'd1);
        check("rst-in-WR resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst-in-WR mem", mem[4], 32'h1234BEEF);
        check("rst-in-WR dm_din", dm_din, 32'h0);
        check("rst-in-WR dm_addr", {22'b0, dm_addr}, 32'd0);
        tick();
        run("LW after rst", LW, 12'h010, 32'h0, 3, 0, 32'h1234BEEF, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
